// File: rtl/vmicro16_rst_seq.sv
// Reset sequencer and watchdog: merges board reset, synchronous reset requests and a
// watchdog into one hold-then-staged-release sequence, and records the last cause.
module vmicro16_rst_seq #(
   parameter int unsigned NUM_SRCS    = 2,
   parameter int unsigned NUM_DOMAINS = 3,
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned STAGE_GAP   = 4,
   parameter int unsigned WDT_WIDTH   = 16,
   parameter int unsigned WDT_TIMEOUT = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_SRCS-1:0]    src_req_i,
   input  logic                   wdt_en_i,
   input  logic                   wdt_kick_i,
   input  logic                   cause_clr_i,
   output logic [NUM_DOMAINS-1:0] domain_reset_o,
   output logic                   all_released_o,
   output logic [NUM_SRCS+1:0]    cause_o,
   output logic [7:0]             rst_count_o
);

   localparam int unsigned CAUSE_W = NUM_SRCS + 2;
   localparam int unsigned HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned GAP_W   = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

   localparam logic [HOLD_W-1:0]      HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]       GAP_LOAD  = GAP_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [WDT_WIDTH-1:0]   WDT_LOAD  = WDT_WIDTH'(WDT_TIMEOUT);
   localparam logic [NUM_DOMAINS-1:0] DOM_LSB   = NUM_DOMAINS'(1);
   localparam logic [CAUSE_W-1:0]     CAUSE_POR = CAUSE_W'(1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t                 state_q;
   logic [HOLD_W-1:0]      hold_q;
   logic [GAP_W-1:0]       gap_q;
   logic [IDX_W-1:0]       idx_q;
   logic [WDT_WIDTH-1:0]   wdt_q;
   logic [NUM_DOMAINS-1:0] domain_reset_q;
   logic                   all_released_q;
   logic [CAUSE_W-1:0]     cause_q;
   logic [7:0]             rst_count_q;

   logic                   wdt_expire;
   logic                   trig;
   logic [CAUSE_W-1:0]     trig_vec;

   // Watchdog can only fire while the system is running
   always_comb begin
      wdt_expire = 1'b0;
      if (state_q == ST_RUN) begin
         wdt_expire = wdt_en_i & (wdt_q == '0) & ~wdt_kick_i;
      end
      trig     = (|src_req_i) | wdt_expire;
      trig_vec = {wdt_expire, src_req_i, 1'b0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_ASSERT;
         hold_q         <= HOLD_LOAD;
         gap_q          <= GAP_LOAD;
         idx_q          <= '0;
         wdt_q          <= WDT_LOAD;
         domain_reset_q <= '1;
         all_released_q <= 1'b0;
         cause_q        <= CAUSE_POR;
         rst_count_q    <= '0;
      end else begin
         if (cause_clr_i) begin
            cause_q <= '0;
         end
         if (trig) begin
            // A trigger restarts the hold; in ASSERT it only extends it
            state_q        <= ST_ASSERT;
            hold_q         <= HOLD_LOAD;
            wdt_q          <= WDT_LOAD;
            domain_reset_q <= '1;
            all_released_q <= 1'b0;
            if (state_q == ST_ASSERT) begin
               cause_q <= cause_q | trig_vec;
            end else begin
               cause_q <= trig_vec;
               if (rst_count_q != 8'hFF) begin
                  rst_count_q <= rst_count_q + 8'd1;
               end
            end
         end else begin
            case (state_q)
               ST_ASSERT: begin
                  domain_reset_q <= '1;
                  wdt_q          <= WDT_LOAD;
                  if (hold_q == '0) begin
                     if (NUM_DOMAINS == 1) begin
                        state_q        <= ST_RUN;
                        domain_reset_q <= '0;
                        all_released_q <= 1'b1;
                     end else begin
                        state_q        <= ST_RELEASE;
                        domain_reset_q <= ~DOM_LSB;
                        gap_q          <= GAP_LOAD;
                        idx_q          <= IDX_W'(1);
                     end
                  end else begin
                     hold_q <= hold_q - HOLD_W'(1);
                  end
               end
               ST_RELEASE: begin
                  wdt_q <= WDT_LOAD;
                  if (gap_q == '0) begin
                     domain_reset_q <= domain_reset_q & ~(DOM_LSB << idx_q);
                     gap_q          <= GAP_LOAD;
                     if (idx_q == IDX_LAST) begin
                        state_q        <= ST_RUN;
                        all_released_q <= 1'b1;
                     end else begin
                        idx_q <= idx_q + IDX_W'(1);
                     end
                  end else begin
                     gap_q <= gap_q - GAP_W'(1);
                  end
               end
               ST_RUN: begin
                  if (!wdt_en_i || wdt_kick_i) begin
                     wdt_q <= WDT_LOAD;
                  end else begin
                     wdt_q <= wdt_q - WDT_WIDTH'(1);
                  end
               end
               default: begin
                  state_q        <= ST_ASSERT;
                  hold_q         <= HOLD_LOAD;
                  domain_reset_q <= '1;
                  all_released_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign domain_reset_o = domain_reset_q;
   assign all_released_o = all_released_q;
   assign cause_o        = cause_q;
   assign rst_count_o    = rst_count_q;

endmodule

// File: tb/tb_vmicro16_rst_seq.sv
// Directed bench for vmicro16_rst_seq (3 domains, hold 8, gap 4, watchdog 20).
module tb_vmicro16_rst_seq;

   localparam int unsigned NS = 2;
   localparam int unsigned ND = 3;
   localparam int unsigned CW = NS + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [NS-1:0] src_req;
   logic          wdt_en;
   logic          wdt_kick;
   logic          cause_clr;
   logic [ND-1:0] domain_reset;
   logic          all_released;
   logic [CW-1:0] cause;
   logic [7:0]    rst_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vmicro16_rst_seq #(
      .NUM_SRCS(NS), .NUM_DOMAINS(ND), .HOLD_CYCLES(8), .STAGE_GAP(4),
      .WDT_WIDTH(16), .WDT_TIMEOUT(20)
   ) dut (
      .clk(clk), .reset(reset), .src_req_i(src_req), .wdt_en_i(wdt_en),
      .wdt_kick_i(wdt_kick), .cause_clr_i(cause_clr),
      .domain_reset_o(domain_reset), .all_released_o(all_released),
      .cause_o(cause), .rst_count_o(rst_count)
   );

   typedef struct {
      logic [NS-1:0] src;
      logic          clr;
      int            rep;
      logic [ND-1:0] dr;
      logic          ar;
      logic [CW-1:0] cause;
      logic [7:0]    cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   function automatic void push(input logic [NS-1:0] s, input logic c, input int r,
                                input logic [ND-1:0] d, input logic a,
                                input logic [CW-1:0] ca, input logic [7:0] n);
      vec_t v;
      v.src = s; v.clr = c; v.rep = r; v.dr = d; v.ar = a; v.cause = ca; v.cnt = n;
      vecs.push_back(v);
   endfunction

   // Idle edges E0..E15 of a full hold/release sequence
   function automatic void add_release(input logic [CW-1:0] ca, input logic [7:0] n);
      push(2'b00, 1'b0, 7, 3'b111, 1'b0, ca, n);
      push(2'b00, 1'b0, 1, 3'b110, 1'b0, ca, n);
      push(2'b00, 1'b0, 3, 3'b110, 1'b0, ca, n);
      push(2'b00, 1'b0, 1, 3'b100, 1'b0, ca, n);
      push(2'b00, 1'b0, 3, 3'b100, 1'b0, ca, n);
      push(2'b00, 1'b0, 1, 3'b000, 1'b1, ca, n);
   endfunction

   task automatic wait_released(input int maxc);
      int c = 0;
      while (all_released !== 1'b1 && c < maxc) begin
         step();
         c++;
      end
      chk("release_timeout", 32'(all_released), 32'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_dr"}, 32'(domain_reset), 32'h7);
      chk({tag, "_ar"}, 32'(all_released), 32'h0);
      chk({tag, "_cause"}, 32'(cause), 32'h1);
      chk({tag, "_cnt"}, 32'(rst_count), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; src_req = '0; wdt_en = 1'b0; wdt_kick = 1'b0; cause_clr = 1'b0;

      // Vector table: power-on, src pulses in RUN / RELEASE / ASSERT, cause_clr
      add_release(4'b0001, 8'd0);
      push(2'b00, 1'b0, 2, 3'b000, 1'b1, 4'b0001, 8'd0);
      push(2'b10, 1'b0, 1, 3'b111, 1'b0, 4'b0100, 8'd1);
      add_release(4'b0100, 8'd1);
      push(2'b00, 1'b1, 1, 3'b000, 1'b1, 4'b0000, 8'd1);
      push(2'b01, 1'b0, 1, 3'b111, 1'b0, 4'b0010, 8'd2);
      push(2'b00, 1'b0, 7, 3'b111, 1'b0, 4'b0010, 8'd2);
      push(2'b00, 1'b0, 3, 3'b110, 1'b0, 4'b0010, 8'd2);
      push(2'b01, 1'b0, 1, 3'b111, 1'b0, 4'b0010, 8'd3);
      add_release(4'b0010, 8'd3);
      push(2'b10, 1'b1, 1, 3'b111, 1'b0, 4'b0100, 8'd4);
      push(2'b00, 1'b0, 3, 3'b111, 1'b0, 4'b0100, 8'd4);
      push(2'b01, 1'b0, 1, 3'b111, 1'b0, 4'b0110, 8'd4);
      add_release(4'b0110, 8'd4);

      repeat (3) step();
      chk_reset_vals("por");
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         for (int r = 0; r < vecs[i].rep; r++) begin
            src_req = vecs[i].src;
            cause_clr = vecs[i].clr;
            step();
            chk($sformatf("vec%0d_dr", i), 32'(domain_reset), 32'(vecs[i].dr));
            chk($sformatf("vec%0d_ar", i), 32'(all_released), 32'(vecs[i].ar));
            chk($sformatf("vec%0d_cause", i), 32'(cause), 32'(vecs[i].cause));
            chk($sformatf("vec%0d_cnt", i), 32'(rst_count), 32'(vecs[i].cnt));
         end
      end
      src_req = '0; cause_clr = 1'b0;

      // Watchdog expiry 20 cycles after RUN entry, reset one edge later
      wdt_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("wdt_pre_expire_ar", 32'(all_released), 32'd1);
      end
      step();
      chk("wdt_expire_dr", 32'(domain_reset), 32'h7);
      chk("wdt_expire_cause", 32'(cause), 32'h8);
      chk("wdt_expire_cnt", 32'(rst_count), 32'd5);
      wait_released(40);

      // Kick arriving exactly when the counter reaches zero still saves it
      wdt_kick = 1'b1; step();
      wdt_kick = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("wdt_zero_ar", 32'(all_released), 32'd1);
      wdt_kick = 1'b1; step();
      chk("wdt_late_kick_ar", 32'(all_released), 32'd1);
      wdt_kick = 1'b0;

      for (int i = 0; i < 200; i++) begin
         wdt_kick = ((i % 10) == 9);
         step();
         chk("wdt_kicked_ar", 32'(all_released), 32'd1);
      end
      wdt_kick = 1'b0;
      chk("wdt_kicked_cnt", 32'(rst_count), 32'd5);

      wdt_en = 1'b0;
      for (int i = 0; i < 200; i++) begin
         step();
         chk("wdt_off_ar", 32'(all_released), 32'd1);
      end
      chk("wdt_off_cnt", 32'(rst_count), 32'd5);

      // Held request keeps everything in reset and counts once
      src_req = 2'b01;
      for (int i = 0; i < 30; i++) begin
         step();
         chk("held_dr", 32'(domain_reset), 32'h7);
      end
      src_req = '0;
      chk("held_cnt", 32'(rst_count), 32'd6);
      chk("held_cause", 32'(cause), 32'h2);
      for (int i = 0; i < 7; i++) step();
      chk("held_e6_dr", 32'(domain_reset), 32'h7);
      step();
      chk("held_e7_dr", 32'(domain_reset), 32'h6);
      wait_released(40);

      // Reset in the middle of RELEASE behaves like power-on
      src_req = 2'b01; step();
      src_req = '0;
      for (int i = 0; i < 10; i++) step();
      chk("mid_release_dr", 32'(domain_reset), 32'h6);
      chk("mid_release_cnt", 32'(rst_count), 32'd7);
      reset = 1'b1; step();
      chk_reset_vals("mid_rst");
      reset = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("mid_rst_e6_dr", 32'(domain_reset), 32'h7);
      step();
      chk("mid_rst_e7_dr", 32'(domain_reset), 32'h6);
      wait_released(40);

      // rst_count saturates at 255
      for (int k = 0; k < 300; k++) begin
         src_req = 2'b10; step();
         src_req = '0;
         if (k == 253) chk("sat_cnt_254", 32'(rst_count), 32'd254);
         wait_released(40);
      end
      chk("sat_cnt_255", 32'(rst_count), 32'd255);
      chk("sat_cause", 32'(cause), 32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
